// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges a line-granular cache port and a burst-oriented memory port. One
// line read or write from the cache becomes an n_beats x s_burst burst to
// memory. Read beats are reassembled into a full line. The cache receives a
// single-cycle resp_o pulse when the transfer finishes.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   line_i     write line from the cache (sampled when a write is accepted)
//   line_o     assembled read line (holds until the next read overwrites it)
//   address_i  cache request address
//   read_i     cache line-read request (level)
//   write_i    cache line-write request (level, wins over read_i)
//   resp_o     one-cycle completion pulse to the cache
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  line-aligned burst address, stable for the whole transfer
//   read_o     burst read request
//   write_o    burst write request
//   resp_i     memory beat strobe, one beat per high cycle
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
   parameter  int s_offset = 5,
   parameter  int s_burst  = 64,
   localparam int s_line   = 8 * (2 ** s_offset),
   localparam int n_beats  = s_line / s_burst,
   localparam int cnt_w    = $clog2(n_beats)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [s_line-1:0]  line_i,
   output logic [s_line-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [s_burst-1:0] burst_i,
   output logic [s_burst-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                          state;
   logic [cnt_w-1:0]                cnt;
   logic [n_beats-1:0][s_burst-1:0] wbuf;
   logic [n_beats-1:0][s_burst-1:0] rbuf;
   logic [31:0]                     addr;
   logic [31:0]                     line_addr;
   logic                            last_beat;

   // Byte offset within the line is dropped so memory always sees a
   // line-aligned burst address.
   assign line_addr = {address_i[31:s_offset], {s_offset{1'b0}}};

   // The final beat of a burst is the strobe that arrives with cnt at its
   // top value; cnt then wraps back to zero on its own.
   assign last_beat = resp_i && (cnt == cnt_w'(n_beats - 1));

   // read_o / write_o / resp_o are flops updated together with state, so
   // they never carry a combinational path from any input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         wbuf    <= '0;
         rbuf    <= '0;
         addr    <= '0;
         read_o  <= 1'b0;
         write_o <= 1'b0;
         resp_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (write_i) begin
                  wbuf    <= line_i;
                  addr    <= line_addr;
                  cnt     <= '0;
                  write_o <= 1'b1;
                  state   <= WRITE;
               end else if (read_i) begin
                  addr    <= line_addr;
                  cnt     <= '0;
                  read_o  <= 1'b1;
                  state   <= READ;
               end
            end

            READ: begin
               // Gaps (resp_i low) simply hold cnt and the assembly buffer.
               if (resp_i) begin
                  rbuf[cnt] <= burst_i;
                  cnt       <= cnt + cnt_w'(1);
                  if (last_beat) begin
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                     state  <= DONE;
                  end
               end
            end

            WRITE: begin
               if (resp_i) begin
                  cnt <= cnt + cnt_w'(1);
                  if (last_beat) begin
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                     state   <= DONE;
                  end
               end
            end

            DONE: begin
               // Requests are not looked at here; a held or re-raised
               // request is picked up from IDLE on the following edge.
               resp_o <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               read_o  <= 1'b0;
               write_o <= 1'b0;
               resp_o  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign address_o = addr;
   assign burst_o   = wbuf[cnt];
   assign line_o    = rbuf;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Bench for cacheline_adaptor: a vector table of whole-line transfers, hand
// sequences for reset, write-back/refill and stray strobes, then random
// transfers checked against a line-level memory model.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

   logic         clk;
   logic         rst_n;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   int checks = 0;
   int errors = 0;

   cacheline_adaptor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic         rd;
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wline;
      logic [255:0] rline;
      logic [31:0]  pat;
      logic [31:0]  exp_addr;
      logic [255:0] exp_line;
      int           exp_lat;
   } vec_t;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk_all_zero(input string nm);
      chk({nm, "_read_o"},    256'(read_o),    '0);
      chk({nm, "_write_o"},   256'(write_o),   '0);
      chk({nm, "_resp_o"},    256'(resp_o),    '0);
      chk({nm, "_address_o"}, 256'(address_o), '0);
      chk({nm, "_burst_o"},   256'(burst_o),   '0);
      chk({nm, "_line_o"},    line_o,          '0);
   endtask

   // One whole-line transfer. Called at a falling edge with the adaptor idle;
   // returns at the falling edge of the idle cycle that follows resp_o.
   // pat bit i gives resp_i for the i-th cycle of the burst. The bench acts as
   // memory: read beats come from rline, write beats are collected into wgot.
   task automatic xfer(input string nm, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [255:0] wline,
                       input logic [255:0] rline, input logic [31:0] pat,
                       input bit drop, input logic chain_rd,
                       input logic [31:0] chain_addr, input logic [31:0] exp_addr,
                       input logic [255:0] exp_line,
                       output int lat, output logic [255:0] wgot);
      int          k;
      int          cyc;
      logic        r;
      logic [63:0] bo;
      k    = 0;
      cyc  = 0;
      wgot = '0;
      read_i    = rd;
      write_i   = wr;
      address_i = addr;
      line_i    = wline;
      @(posedge clk);
      @(negedge clk);
      while (k < 4 && cyc < 64) begin
         chk({nm, "_write_o"},   256'(write_o),   256'(wr));
         chk({nm, "_read_o"},    256'(read_o),    256'(!wr));
         chk({nm, "_address_o"}, 256'(address_o), 256'(exp_addr));
         chk({nm, "_resp_busy"}, 256'(resp_o),    '0);
         bo = burst_o;
         if (wr) chk({nm, "_burst_o"}, 256'(bo), 256'(wline[k*64 +: 64]));
         r       = pat[cyc % 32];
         resp_i  = r;
         burst_i = r ? rline[k*64 +: 64] : {$urandom, $urandom};
         if (drop && cyc == 1) begin
            read_i  = 1'b0;
            write_i = 1'b0;
         end
         @(posedge clk);
         if (r) begin
            wgot[k*64 +: 64] = bo;
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      resp_i  = 1'b0;
      burst_i = '0;
      lat     = cyc + 1;
      if (k < 4) chk({nm, "_beats_timeout"}, 256'(k), 256'(4));
      chk({nm, "_done_resp_o"},    256'(resp_o),    256'(1));
      chk({nm, "_done_read_o"},    256'(read_o),    '0);
      chk({nm, "_done_write_o"},   256'(write_o),   '0);
      chk({nm, "_done_address_o"}, 256'(address_o), 256'(exp_addr));
      read_i    = chain_rd;
      write_i   = 1'b0;
      address_i = chain_addr;
      @(negedge clk);
      chk({nm, "_idle_resp_o"},  256'(resp_o),  '0);
      chk({nm, "_idle_read_o"},  256'(read_o),  '0);
      chk({nm, "_idle_write_o"}, 256'(write_o), '0);
      chk({nm, "_line_o"},       line_o,        exp_line);
   endtask

   localparam logic [255:0] R0 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
   localparam logic [255:0] R3 = 256'hA5A5_0000_1111_2222_5A5A_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
   localparam logic [255:0] W1 = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;

   initial begin
      vec_t         vecs[4];
      logic [255:0] cur_line;
      logic [255:0] wgot;
      logic [255:0] wl;
      logic [255:0] rl;
      logic [31:0]  a;
      int           lat;
      logic [255:0] mem [logic [26:0]];

      rst_n     = 1'b0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      resp_i    = 1'b0;
      address_i = '0;
      line_i    = '0;
      burst_i   = '0;

      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // rd wr addr wline rline pat exp_addr exp_line exp_lat
      vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, '0,   R0,  32'h0000_000F, 32'h0000_1220, R0, 5};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_ABCD, W1,   '0,  32'h0000_0059, 32'h0000_ABC0, R0, 8};
      vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF, ~W1,  R3,  32'h0000_000F, 32'hFFFF_FFE0, R0, 5};
      vecs[3] = '{1'b1, 1'b0, 32'h8000_005F, '0,   R3,  32'h0000_001D, 32'h8000_0040, R3, 6};

      for (int i = 0; i < 4; i++) begin
         xfer($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
              vecs[i].wline, vecs[i].rline, vecs[i].pat, 1'b0, 1'b0, 32'h0,
              vecs[i].exp_addr, vecs[i].exp_line, lat, wgot);
         chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].exp_lat));
         if (vecs[i].wr)
            chk($sformatf("vec%0d_wline", i), wgot, vecs[i].wline);
      end
      cur_line = R3;

      // Write-back then refill: read_i rises during the resp_o cycle.
      xfer("wb", 1'b0, 1'b1, 32'h2000_0044, W1 ^ R0, '0, 32'h0000_000F, 1'b0,
           1'b1, 32'h2000_0050, 32'h2000_0040, cur_line, lat, wgot);
      chk("wb_wline", wgot, W1 ^ R0);
      xfer("refill", 1'b1, 1'b0, 32'h2000_0050, '0, R0 ^ R3, 32'h0000_000F, 1'b0,
           1'b0, 32'h0, 32'h2000_0040, R0 ^ R3, lat, wgot);
      chk("refill_latency", 256'(lat), 256'(5));
      cur_line = R0 ^ R3;

      // Stray memory strobes while idle must be ignored.
      resp_i  = 1'b1;
      burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stray_resp_o",  256'(resp_o),  '0);
         chk("stray_read_o",  256'(read_o),  '0);
         chk("stray_write_o", 256'(write_o), '0);
         chk("stray_line_o",  line_o,        cur_line);
      end
      resp_i  = 1'b0;
      burst_i = '0;
      xfer("post_stray", 1'b1, 1'b0, 32'h0000_0200, '0, R3 ^ W1, 32'h0000_000F, 1'b0,
           1'b0, 32'h0, 32'h0000_0200, R3 ^ W1, lat, wgot);
      chk("post_stray_latency", 256'(lat), 256'(5));

      // Asynchronous reset in the middle of a write burst, at beat 2.
      write_i   = 1'b1;
      address_i = 32'h0000_0100;
      line_i    = W1;
      @(posedge clk);
      @(negedge clk);
      resp_i = 1'b1;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      resp_i  = 1'b0;
      write_i = 1'b0;
      chk("midwr_write_o", 256'(write_o), 256'(1));
      chk("midwr_burst_o", 256'(burst_o), 256'(W1[128 +: 64]));
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      xfer("after_reset", 1'b1, 1'b0, 32'h0000_0300, '0, R0 ^ W1, 32'h0000_000F, 1'b0,
           1'b0, 32'h0, 32'h0000_0300, R0 ^ W1, lat, wgot);
      chk("after_reset_latency", 256'(lat), 256'(5));
      cur_line = R0 ^ W1;

      // Random transfers against a line-addressed memory model: a write stores
      // the line delivered over the bus, a read must return the stored line.
      for (int n = 0; n < 40; n++) begin
         a = 32'h4000_0000 + 32'($urandom_range(0, 3)) * 32'd32 + 32'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) begin
            wl = rand256();
            xfer($sformatf("rnd%0d_wr", n), 1'b0, 1'b1, a, wl, rand256(),
                 $urandom | 32'h8888_8888, ($urandom_range(0, 3) == 0), 1'b0, 32'h0,
                 a & 32'hFFFF_FFE0, cur_line, lat, wgot);
            chk($sformatf("rnd%0d_wline", n), wgot, wl);
            mem[a[31:5]] = wgot;
         end else begin
            if (mem.exists(a[31:5])) rl = mem[a[31:5]];
            else begin
               rl = rand256();
               mem[a[31:5]] = rl;
            end
            xfer($sformatf("rnd%0d_rd", n), 1'b1, 1'b0, a, rand256(), rl,
                 $urandom | 32'h8888_8888, ($urandom_range(0, 3) == 0), 1'b0, 32'h0,
                 a & 32'hFFFF_FFE0, rl, lat, wgot);
            cur_line = rl;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
